// File: rtl/osd_cmd_seq.sv
// -----------------------------------------------------------------------------
// osd_cmd_seq
//   Drives the OSD io port (io_osd / io_strobe / io_din) on behalf of two
//   requesters. One request is one OSD transaction: a command word followed by
//   len data words fetched from the owner's buffer over a 1-cycle read port.
//   Requesters are arbitrated round-robin when both ask in the same IDLE cycle.
//
// Ports
//   clk_sys, reset        clock, asynchronous active-high reset
//   req[1:0]              level requests, sampled only in IDLE
//   cmd0/len0, cmd1/len1  command byte and data word count per requester
//   grant[1:0]            one-hot owner, high for the whole transaction
//   ack[1:0]              one-cycle pulse in the final GAP cycle
//   busy                  high whenever not IDLE
//   src_rd, src_addr      read port into the owner's buffer
//   src_data0/1           buffer read data, valid the cycle after src_rd
//   io_osd, io_strobe,    frame, word strobe (rising edge latches) and word
//   io_din
// -----------------------------------------------------------------------------
module osd_cmd_seq #(
   parameter int STB_CYCLES = 2,
   parameter int GAP_CYCLES = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [7:0]  cmd0,
   input  logic [12:0] len0,
   input  logic [7:0]  cmd1,
   input  logic [12:0] len1,
   output logic [1:0]  grant,
   output logic [1:0]  ack,
   output logic        busy,
   output logic        src_rd,
   output logic [12:0] src_addr,
   input  logic [15:0] src_data0,
   input  logic [15:0] src_data1,
   output logic        io_osd,
   output logic        io_strobe,
   output logic [15:0] io_din
);

   localparam int CW = 16;
   localparam logic [CW-1:0] STB_LAST = CW'(STB_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HI    = 3'd2,
      S_LO    = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q,   cnt_d;    // cycles spent in current HI/LO/GAP phase
   logic [12:0]   k_q,     k_d;      // data words already fetched
   logic [12:0]   len_q,   len_d;
   logic          own_q,   own_d;    // owner index (0/1)
   logic [1:0]    grant_q, grant_d;
   logic          rr_q,    rr_d;     // last winner; the other one wins a tie
   logic [15:0]   din_q,   din_d;
   logic          rd_q,    rd_d;     // a word was fetched in this LO phase
   logic          win;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         k_q     <= '0;
         len_q   <= '0;
         own_q   <= 1'b0;
         grant_q <= '0;
         rr_q    <= 1'b1;
         din_q   <= '0;
         rd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         len_q   <= len_d;
         own_q   <= own_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         din_q   <= din_d;
         rd_q    <= rd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      len_d    = len_q;
      own_d    = own_q;
      grant_d  = grant_q;
      rr_d     = rr_q;
      din_d    = din_q;
      rd_d     = rd_q;
      win      = 1'b0;
      src_rd   = 1'b0;
      src_addr = '0;
      ack      = '0;

      unique case (state_q)
         S_IDLE: begin
            if (req != 2'b00) begin
               // tie goes to the requester that did not win last time
               win     = (req == 2'b11) ? ~rr_q : req[1];
               own_d   = win;
               rr_d    = win;
               len_d   = win ? len1 : len0;
               din_d   = {8'h00, (win ? cmd1 : cmd0)};
               grant_d = win ? 2'b10 : 2'b01;
               k_d     = '0;
               cnt_d   = '0;
               state_d = S_SETUP;
            end
         end

         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_HI;
         end

         S_HI: begin
            if (cnt_q == STB_LAST) begin
               cnt_d   = '0;
               state_d = S_LO;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_LO: begin
            // first LO cycle: decide whether another word follows and fetch it
            if (cnt_q == '0) begin
               rd_d = (k_q != len_q);
               if (k_q != len_q) begin
                  src_rd   = 1'b1;
                  src_addr = k_q;
               end
            end
            // second LO cycle: read data is valid, stage it for the next HI
            if (cnt_q == CW'(1) && rd_q) begin
               din_d = own_q ? src_data1 : src_data0;
               k_d   = k_q + 13'd1;
            end
            if (cnt_q == STB_LAST) begin
               cnt_d   = '0;
               state_d = rd_q ? S_HI : S_GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               ack     = grant_q;
               grant_d = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Frame/strobe decode straight from state so an async reset clears them at once.
   assign busy      = (state_q != S_IDLE);
   assign io_osd    = (state_q == S_SETUP) || (state_q == S_HI) || (state_q == S_LO);
   assign io_strobe = (state_q == S_HI);
   assign io_din    = din_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_osd_cmd_seq.sv
module tb_osd_cmd_seq;
   localparam int STB = 2;
   localparam int GAP = 4;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic [1:0]  req     = '0;
   logic [7:0]  cmd0 = '0, cmd1 = '0;
   logic [12:0] len0 = '0, len1 = '0;
   logic [1:0]  grant, ack;
   logic        busy, src_rd, io_osd, io_strobe;
   logic [12:0] src_addr;
   logic [15:0] src_data0 = '0, src_data1 = '0, io_din;

   int total = 0;
   int bad   = 0;
   int last_w = 1;          // reference arbiter memory: previous winner
   logic [15:0] seed0 = 16'h0000;
   logic [15:0] base1 = 16'h00A0;

   osd_cmd_seq #(.STB_CYCLES(STB), .GAP_CYCLES(GAP)) dut (
      .clk_sys(clk_sys), .reset(reset), .req(req),
      .cmd0(cmd0), .len0(len0), .cmd1(cmd1), .len1(len1),
      .grant(grant), .ack(ack), .busy(busy),
      .src_rd(src_rd), .src_addr(src_addr),
      .src_data0(src_data0), .src_data1(src_data1),
      .io_osd(io_osd), .io_strobe(io_strobe), .io_din(io_din)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [15:0] mem(input int o, input logic [12:0] a);
      if (o == 1) return base1 + 16'(a);
      return (16'(a) * 16'd3) ^ seed0;
   endfunction

   // Buffer model: 1-cycle read latency, junk on cycles without a read.
   always @(posedge clk_sys) begin
      if (src_rd) begin
         src_data0 <= mem(0, src_addr);
         src_data1 <= mem(1, src_addr);
      end else begin
         src_data0 <= 16'($urandom);
         src_data1 <= 16'($urandom);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference round-robin: lone requester wins; on a tie the non-previous one wins.
   function automatic int pick(input logic [1:0] r);
      int w;
      if (r == 2'b11) w = 1 - last_w;
      else            w = r[1] ? 1 : 0;
      last_w = w;
      return w;
   endfunction

   // Observe one whole transaction from SETUP to the following IDLE cycle.
   task automatic run_txn(input int o, input logic [7:0] c, input logic [12:0] n, input int drop_at);
      logic [15:0] words[$];
      logic [12:0] addrs[$];
      int started = 0, done = 0, idx = 0, osd_hi = 0, osd_rise = 0, rd_bad = 0;
      int ack_n = 0, ack_at = -1, grant_bad = 0;
      logic [1:0] ack_v = '0, exp_g;
      logic prev_stb = 1'b0, prev_osd = 1'b0, grant_idle = 1'b1;
      exp_g = (o == 1) ? 2'b10 : 2'b01;
      for (int t = 0; t < 40000 && !done; t++) begin
         @(negedge clk_sys);
         if (!started && busy) started = 1;
         if (started) begin
            if (!busy) begin
               grant_idle = (grant == 2'b00);
               done = 1;
            end else begin
               if (grant !== exp_g) grant_bad++;
               if (io_osd) osd_hi++;
               if (io_osd && !prev_osd) osd_rise++;
               if (io_strobe && !prev_stb) words.push_back(io_din);
               if (src_rd) begin
                  addrs.push_back(src_addr);
                  if (!io_osd || io_strobe) rd_bad++;
               end
               if (ack != 2'b00) begin
                  ack_v = ack; ack_n++; ack_at = idx;
                  req[o] = 1'b0;
               end
               if (drop_at > 0 && words.size() == drop_at) req[o] = 1'b0;
               prev_stb = io_strobe;
               prev_osd = io_osd;
               idx++;
            end
         end
      end
      chk("txn_finished", 32'(done), 32'd1);
      chk("grant_onehot_held", 32'(grant_bad), 32'd0);
      chk("grant_drop_idle", 32'(grant_idle), 32'd1);
      chk("osd_high_cycles", 32'(osd_hi), 32'(1 + (int'(n) + 1) * 2 * STB));
      chk("osd_one_window", 32'(osd_rise), 32'd1);
      chk("strobe_count", 32'(words.size()), 32'(int'(n) + 1));
      chk("src_rd_count", 32'(addrs.size()), 32'(n));
      chk("src_rd_in_lo", 32'(rd_bad), 32'd0);
      chk("ack_value", 32'(ack_v), 32'(exp_g));
      chk("ack_once", 32'(ack_n), 32'd1);
      chk("ack_cycle", 32'(ack_at), 32'(1 + (int'(n) + 1) * 2 * STB + GAP - 1));
      if (words.size() == int'(n) + 1) begin
         chk("cmd_word", 32'(words[0]), {24'h0, c});
         for (int i = 1; i <= int'(n); i++) chk("data_word", 32'(words[i]), 32'(mem(o, 13'(i - 1))));
      end
      if (addrs.size() == int'(n)) begin
         for (int i = 0; i < int'(n); i++) chk("src_addr", 32'(addrs[i]), 32'(i));
      end
   endtask

   initial begin
      int o, rises, nb, na;
      logic prev;
      // reset state
      #12;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_osd", 32'({io_osd, io_strobe, src_rd}), 32'd0);
      chk("rst_din", 32'(io_din), 32'd0);
      @(negedge clk_sys); reset = 1'b0;
      seed0 = 16'($urandom);

      // 1: command-only enable
      cmd0 = 8'h41; len0 = 13'd0; req = 2'b01;
      o = pick(req); run_txn(o, cmd0, len0, 0);

      // 2: write with 4 data words
      cmd1 = 8'h20; len1 = 13'd4; base1 = 16'h00A0; req = 2'b10;
      o = pick(req); run_txn(o, cmd1, len1, 0);

      // 3: both held, each drops on its ack; then both again
      cmd0 = 8'h41; len0 = 13'd2; cmd1 = 8'h20; len1 = 13'd3;
      for (int rep = 0; rep < 2; rep++) begin
         req = 2'b11;
         o = pick(req); chk("rr_first", 32'(o), 32'd0);
         run_txn(o, cmd0, len0, 0);
         o = pick(req); chk("rr_second", 32'(o), 32'd1);
         run_txn(o, cmd1, len1, 0);
      end

      // 4: reset during the 3rd data word
      cmd1 = 8'h20; len1 = 13'd4; req = 2'b10;
      rises = 0; prev = 1'b0;
      for (int t = 0; t < 200 && rises < 4; t++) begin
         @(negedge clk_sys);
         if (io_strobe && !prev) rises++;
         prev = io_strobe;
      end
      chk("reach_3rd_word", 32'(rises), 32'd4);
      #2 reset = 1'b1; req = 2'b00;
      #1;
      chk("arst_grant", 32'(grant), 32'd0);
      chk("arst_ctl", 32'({ack, busy, src_rd, io_osd, io_strobe}), 32'd0);
      chk("arst_bus", 32'({src_addr, io_din}), 32'd0);
      @(negedge clk_sys); reset = 1'b0; last_w = 1;
      nb = 0; na = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk_sys);
         if (busy) nb++;
         if (ack != 2'b00) na++;
      end
      chk("post_rst_idle", 32'(nb), 32'd0);
      chk("post_rst_no_ack", 32'(na), 32'd0);
      cmd0 = 8'h41; len0 = 13'd1; req = 2'b01;
      o = pick(req); run_txn(o, cmd0, len0, 0);

      // 5: requester 1 drops req during the 2nd strobe
      cmd1 = 8'h20; len1 = 13'd4; req = 2'b10;
      o = pick(req); run_txn(o, cmd1, len1, 2);
      nb = 0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk_sys);
         if (busy) nb++;
      end
      chk("no_restart_after_drop", 32'(nb), 32'd0);

      // random transactions
      for (int r = 0; r < 8; r++) begin
         cmd0 = 8'($urandom); cmd1 = 8'($urandom);
         len0 = 13'($urandom_range(0, 12)); len1 = 13'($urandom_range(0, 12));
         base1 = 16'($urandom); seed0 = 16'($urandom);
         req = 2'($urandom_range(1, 3));
         while (req != 2'b00) begin
            o = pick(req);
            run_txn(o, (o == 1) ? cmd1 : cmd0, (o == 1) ? len1 : len0, 0);
         end
      end

      // 6: maximum length
      cmd0 = 8'h20; len0 = 13'h1FFF; seed0 = 16'($urandom); req = 2'b01;
      o = pick(req); run_txn(o, cmd0, len0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
